// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Misaligned byte address, or any bit set above the addressable word range.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed 32-bit storage: synchronous byte-enabled write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] widx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[widx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with WAIT_CYCLES wait states and a one-cycle Ack.
// Optional byte strobes (port Be) enabled by defining DMEM_BYTE_STROBE_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              Req,
  input  logic              We,
  input  logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] Wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        Be,
`endif
  output logic [WORD_W-1:0] Rdata,
  output logic              Ack,
  output logic              Err,
  output logic              Busy
);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q;
  logic [WORD_W-1:0]     addr_q, wdata_q;
  logic                  ack_q, err_q;
  logic [WORD_W-1:0]     rdata_q;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]            be_q;
`endif

  logic                  capture, enter_resp;
  logic                  cur_we, cur_err, mem_we;
  logic [WORD_W-1:0]     cur_addr, cur_wdata, mem_rdata;
  logic [3:0]            cur_be;
  logic [ADDR_WIDTH-1:0] widx;

  assign capture = (state_q == S_IDLE) && Req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          cnt_d = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered straight from IDLE, so the live
  // inputs are the request; otherwise the latched copy is.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = We;
      cur_addr  = Addr;
      cur_wdata = Wdata;
`ifdef DMEM_BYTE_STROBE_EN
      cur_be    = Be;
`else
      cur_be    = 4'hF;
`endif
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
      cur_be    = be_q;
`else
      cur_be    = 4'hF;
`endif
    end
  end

  assign cur_err = addr_err(cur_addr, ADDR_WIDTH);
  assign widx    = cur_addr[ADDR_WIDTH+1:2];
  assign mem_we  = enter_resp && cur_we && !cur_err;

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .Clk  (Clk),
    .we   (mem_we),
    .be   (cur_be),
    .widx (widx),
    .wdata(cur_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      be_q    <= '0;
`endif
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= We;
        addr_q  <= Addr;
        wdata_q <= Wdata;
`ifdef DMEM_BYTE_STROBE_EN
        be_q    <= Be;
`endif
      end
      ack_q   <= enter_resp;
      err_q   <= enter_resp && cur_err;
      rdata_q <= (enter_resp && !cur_we && !cur_err) ? mem_rdata : '0;
    end
  end

  assign Ack   = ack_q;
  assign Err   = err_q;
  assign Rdata = rdata_q;
  assign Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) checked against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2_n, rst0_n, req2, req0, we;
  logic [31:0] addr, wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  be;
`endif
  logic [31:0] rdata2, rdata0;
  logic        ack2, ack0, err2, err0, busy2, busy0;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
    .Clk(clk), .Clrn(rst2_n), .Req(req2), .We(we), .Addr(addr), .Wdata(wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .Be(be),
`endif
    .Rdata(rdata2), .Ack(ack2), .Err(err2), .Busy(busy2));

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .Clrn(rst0_n), .Req(req0), .We(we), .Addr(addr), .Wdata(wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .Be(be),
`endif
    .Rdata(rdata0), .Ack(ack0), .Err(err0), .Busy(busy0));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q2[$], q0[$];
  logic [31:0] m2 [256];
  logic [31:0] m0 [256];
  int          checks = 0, errors = 0, cyc = 0;
  bit          skip_busy2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic err_of(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd1 << (AW + 2)));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Issue one request to the selected DUTs; capture happens at the next rising edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input bit en2, input bit en0, input bit use_xp, input logic [31:0] xp);
    exp_t        e;
    logic [3:0]  eb;
    int unsigned idx;
    @(negedge clk);
    we = w; addr = a; wdata = d; req2 = en2; req0 = en0;
`ifdef DMEM_BYTE_STROBE_EN
    be = b; eb = b;
`else
    eb = 4'hF;
`endif
    idx   = (a >> 2) % 256;
    e.err = err_of(a);
    if (en2) begin
      e.cyc = cyc + 1 + 2;
      if (w) begin
        e.rdata = '0;
        if (!e.err) m2[idx] = merge(m2[idx], d, eb);
      end else e.rdata = e.err ? 32'd0 : m2[idx];
      if (use_xp) e.rdata = xp;
      q2.push_back(e);
    end
    if (en0) begin
      e.cyc = cyc + 1;
      if (w) begin
        e.rdata = '0;
        if (!e.err) m0[idx] = merge(m0[idx], d, eb);
      end else e.rdata = e.err ? 32'd0 : m0[idx];
      if (use_xp) e.rdata = xp;
      q0.push_back(e);
    end
    @(posedge clk); #1;
    req2 = 1'b0; req0 = 1'b0;
    we = 1'($urandom); addr = $urandom; wdata = $urandom;
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ack2) begin
      chk("busy2_resp", 32'(busy2), 32'd1);
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack2_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q2.pop_front();
        chk("ack2_cycle", cyc, e.cyc);
        chk("rdata2", rdata2, e.rdata);
        chk("err2", 32'(err2), 32'(e.err));
      end
    end else begin
      chk("rdata2_idle", rdata2, 32'd0);
      chk("err2_idle", 32'(err2), 32'd0);
      if (q2.size() == 0 && !skip_busy2) chk("busy2_idle", 32'(busy2), 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ack0) begin
      chk("busy0_resp", 32'(busy0), 32'd1);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack0_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("ack0_cycle", cyc, e.cyc);
        chk("rdata0", rdata0, e.rdata);
        chk("err0", 32'(err0), 32'(e.err));
      end
    end else begin
      chk("rdata0_idle", rdata0, 32'd0);
      chk("err0_idle", 32'(err0), 32'd0);
      if (q0.size() == 0) chk("busy0_idle", 32'(busy0), 32'd0);
    end
  end

  function automatic logic [31:0] rand_addr();
    int unsigned idx = $urandom_range(0, 15);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = {idx[29:0], 2'b00} | 32'($urandom_range(1, 3));
      1: begin a = $urandom; if (a < 32'h400) a = a | 32'h400; end
      default: a = {idx[29:0], 2'b00};
    endcase
    return a;
  endfunction

  initial begin
    int c, guard;
    rst2_n = 1'b0; rst0_n = 1'b0; req2 = 1'b0; req0 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0;
`ifdef DMEM_BYTE_STROBE_EN
    be = 4'hF;
`endif
    repeat (2) @(negedge clk);
    chk("reset_busy2", 32'(busy2), 32'd0);
    chk("reset_ack2", 32'(ack2), 32'd0);
    chk("reset_rdata2", rdata2, 32'd0);
    chk("reset_busy0", 32'(busy0), 32'd0);
    rst2_n = 1'b1; rst0_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1, 1'b1, 1'b0, '0);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0, '0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    issue(1'b1, 32'h12, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 1'b0, '0);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    issue(1'b0, 32'h400, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, '0);

`ifdef DMEM_BYTE_STROBE_EN
    issue(1'b1, 32'h30, 32'h11223344, 4'hF, 1'b1, 1'b1, 1'b0, '0);
    issue(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b1, 1'b0, '0);
    issue(1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h11BB33DD);
    issue(1'b1, 32'h30, 32'h99999999, 4'h0, 1'b1, 1'b1, 1'b0, '0);
    issue(1'b0, 32'h30, 32'h0, 4'hF, 1'b1, 1'b1, 1'b1, 32'h11BB33DD);
`endif

    // Abandoned store: reset the 2-wait-state responder while it waits.
    @(negedge clk);
    skip_busy2 = 1'b1;
    we = 1'b1; addr = 32'h20; wdata = 32'h55AA55AA; req2 = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy2), 32'd1);
    rst2_n = 1'b0;
    #1;
    chk("midrst_busy_after", 32'(busy2), 32'd0);
    chk("midrst_ack", 32'(ack2), 32'd0);
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    skip_busy2 = 1'b0;
    repeat (10) @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0, '0);

    // Req held high through Ack: next capture only at the first IDLE edge.
    @(negedge clk);
    c = cyc;
    we = 1'b0; addr = 32'h10; req2 = 1'b1; req0 = 1'b0;
    q2.push_back('{rdata: m2[4], err: 1'b0, cyc: c + 1 + 2});
    q2.push_back('{rdata: m2[4], err: 1'b0, cyc: c + 1 + 4 + 2});
    repeat (5) @(negedge clk);
    req2 = 1'b0;
    repeat (6) @(negedge clk);
    c = cyc;
    req0 = 1'b1;
    q0.push_back('{rdata: m0[4], err: 1'b0, cyc: c + 1});
    q0.push_back('{rdata: m0[4], err: 1'b0, cyc: c + 3});
    repeat (3) @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 200; i++)
      issue(1'($urandom), rand_addr(), $urandom, 4'($urandom), 1'b1, 1'b1, 1'b0, '0);

    guard = 0;
    while ((q2.size() != 0 || q0.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (q2.size() != 0 || q0.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0 outstanding responses", q2.size(), q0.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
